// File: rtl/comparator_arbiter.sv
// comparator_arbiter: round-robin arbitration of REQ_NUM requesters onto one
// shared DATA_WIDTH magnitude comparator. One transaction is in flight at a time.
// Build option: define CMP_ARB_SIGNED_EN to compare operands as two's-complement
// signed values. The default build compares them as unsigned.
module comparator_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int REQ_NUM    = 4,
  localparam int ID_WIDTH  = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [REQ_NUM-1:0]            req_valid_i,
  output logic [REQ_NUM-1:0]            req_ready_o,
  input  logic [REQ_NUM*DATA_WIDTH-1:0] req_data_0_i,
  input  logic [REQ_NUM*DATA_WIDTH-1:0] req_data_1_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [ID_WIDTH-1:0]           rsp_id_o,
  output logic                          rsp_equal_o,
  output logic                          rsp_greater_o,
  output logic                          rsp_lower_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_RESPOND = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [DATA_WIDTH-1:0] op0_q, op0_d;
  logic [DATA_WIDTH-1:0] op1_q, op1_d;
  logic                  eq_q, eq_d;
  logic                  gt_q, gt_d;
  logic                  lt_q, lt_d;

  // Per-requester operand views of the packed input buses.
  logic [DATA_WIDTH-1:0] op0_arr [REQ_NUM];
  logic [DATA_WIDTH-1:0] op1_arr [REQ_NUM];

  genvar gi;
  generate
    for (gi = 0; gi < REQ_NUM; gi++) begin : g_unpack
      assign op0_arr[gi] = req_data_0_i[gi*DATA_WIDTH +: DATA_WIDTH];
      assign op1_arr[gi] = req_data_1_i[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Comparator on the latched operands.
  logic cmp_eq, cmp_gt, cmp_lt;
  assign cmp_eq = (op0_q == op1_q);
`ifdef CMP_ARB_SIGNED_EN
  assign cmp_gt = ($signed(op0_q) > $signed(op1_q));
  assign cmp_lt = ($signed(op0_q) < $signed(op1_q));
`else
  assign cmp_gt = (op0_q > op1_q);
  assign cmp_lt = (op0_q < op1_q);
`endif

  // Round-robin search: first valid requester at or after the pointer, wrapping.
  logic                found;
  logic [ID_WIDTH-1:0] grant_id;
  logic [ID_WIDTH-1:0] cand;
  int                  sum;
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    cand     = '0;
    sum      = 0;
    for (int i = 0; i < REQ_NUM; i++) begin
      sum = int'(ptr_q) + i;
      if (sum >= REQ_NUM) sum = sum - REQ_NUM;
      cand = ID_WIDTH'(sum);
      if (!found && req_valid_i[cand]) begin
        found    = 1'b1;
        grant_id = cand;
      end
    end
  end

  // Next-state logic and request-side ready; ready is only offered in IDLE.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    op0_d       = op0_q;
    op1_d       = op1_q;
    eq_d        = eq_q;
    gt_d        = gt_q;
    lt_d        = lt_q;
    req_ready_o = '0;
    case (state_q)
      ST_IDLE: begin
        if (found && !rst_i) begin
          req_ready_o[grant_id] = 1'b1;
          op0_d   = op0_arr[grant_id];
          op1_d   = op1_arr[grant_id];
          id_d    = grant_id;
          ptr_d   = (int'(grant_id) == REQ_NUM - 1) ? '0 : grant_id + 1'b1;
          state_d = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        eq_d    = cmp_eq;
        gt_d    = cmp_gt;
        lt_d    = cmp_lt;
        state_d = ST_RESPOND;
      end
      ST_RESPOND: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, pointer, operand and result registers; reset discards any in-flight work.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      op0_q   <= '0;
      op1_q   <= '0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      op0_q   <= op0_d;
      op1_q   <= op1_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
    end
  end

  assign rsp_valid_o   = (state_q == ST_RESPOND);
  assign rsp_id_o      = id_q;
  assign rsp_equal_o   = eq_q;
  assign rsp_greater_o = gt_q;
  assign rsp_lower_o   = lt_q;

endmodule

// File: tb/tb_comparator_arbiter.sv
// Testbench for comparator_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_comparator_arbiter;

  localparam int DW  = 8;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    valid;
  logic [N-1:0]    ready;
  logic [N*DW-1:0] d0, d1;
  logic            rsp_valid, rsp_ready;
  logic [IDW-1:0]  rsp_id;
  logic            eq, gt, lt;

  int checks = 0;
  int errors = 0;

  comparator_arbiter #(.DATA_WIDTH(DW), .REQ_NUM(N)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (valid),
    .req_ready_o  (ready),
    .req_data_0_i (d0),
    .req_data_1_i (d1),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_id_o     (rsp_id),
    .rsp_equal_o  (eq),
    .rsp_greater_o(gt),
    .rsp_lower_o  (lt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (transaction level) ----------------
  int          m_rr;
  bit          m_busy;
  int          m_cyc;    // cycles since the request was accepted
  int          m_id;
  logic [DW-1:0] m_a, m_b;

  logic [N-1:0] exp_ready;
  int           exp_grant;
  bit           exp_valid;
  int           exp_id;
  bit           exp_eq, exp_gt, exp_lt;

  function automatic void flags_of(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                   output bit e, output bit g, output bit l);
    int ia, ib;
`ifdef CMP_ARB_SIGNED_EN
    ia = int'($signed(a));
    ib = int'($signed(b));
`else
    ia = int'(a);
    ib = int'(b);
`endif
    e = (ia == ib);
    g = (ia > ib);
    l = (ia < ib);
  endfunction

  task automatic model_reset();
    m_rr   = 0;
    m_busy = 0;
    m_cyc  = 0;
    m_id   = 0;
    m_a    = '0;
    m_b    = '0;
  endtask

  task automatic model_expect();
    exp_ready = '0;
    exp_grant = -1;
    if (!m_busy && !rst) begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_rr + i) % N;
        if (exp_grant < 0 && valid[k]) exp_grant = k;
      end
    end
    if (exp_grant >= 0) exp_ready[exp_grant] = 1'b1;
    exp_valid = m_busy && (m_cyc >= 2);
    exp_id    = m_id;
    flags_of(m_a, m_b, exp_eq, exp_gt, exp_lt);
  endtask

  task automatic model_update();
    if (exp_grant >= 0) begin
      m_busy = 1;
      m_cyc  = 1;
      m_id   = exp_grant;
      m_a    = d0[exp_grant*DW +: DW];
      m_b    = d1[exp_grant*DW +: DW];
      m_rr   = (exp_grant + 1) % N;
    end else if (m_busy) begin
      if (m_cyc < 2) m_cyc++;
      else if (rsp_ready) begin
        $display("rsp id=%0d a=%02h b=%02h eq=%0d gt=%0d lt=%0d", m_id, m_a, m_b, exp_eq, exp_gt, exp_lt);
        m_busy = 0;
      end
    end
  endtask

  // Advance one cycle: evaluate the model on current inputs, cross the edge,
  // update the model, return at the falling edge.
  task automatic tick();
    model_expect();
    @(posedge clk);
    if (!rst) model_update();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    valid     = '0;
    rsp_ready = 1'b0;
    rst       = 1'b1;
    model_reset();
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst       = 1'b1;
    valid     = '1;
    d0        = $urandom;
    d1        = $urandom;
    rsp_ready = 1'b1;
    model_reset();
    @(negedge clk);
    #1;
    checks++; if (ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_id got=%0d exp=0", rsp_id); end
    checks++; if ({eq, gt, lt} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {eq, gt, lt}); end
    valid = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single();
    apply_reset();
    valid = 4'b0100;
    d0[2*DW +: DW] = 8'h10;
    d1[2*DW +: DW] = 8'h10;
    rsp_ready = 1'b1;
    #1;
    checks++; if (ready !== 4'b0100) begin errors++; $display("FAIL single_ready got=%b exp=0100", ready); end
    tick();
    valid = '0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_compare_valid got=%b exp=0", rsp_valid); end
    tick();
    #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL single_id got=%0d exp=2", rsp_id); end
    checks++; if ({eq, gt, lt} !== 3'b100) begin errors++; $display("FAIL single_flags got=%b exp=100", {eq, gt, lt}); end
    tick();
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_idle_valid got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_round_robin();
    int g[$];
    int order[5] = '{0, 1, 2, 3, 0};
    apply_reset();
    valid     = '1;
    rsp_ready = 1'b1;
    repeat (15) begin
      d0 = $urandom;
      d1 = $urandom;
      #1;
      model_expect();
      checks++; if (ready !== exp_ready) begin errors++; $display("FAIL rr_ready got=%b exp=%b", ready, exp_ready); end
      checks++; if (rsp_valid !== exp_valid) begin errors++; $display("FAIL rr_rsp_valid got=%b exp=%b", rsp_valid, exp_valid); end
      if (exp_valid) begin
        checks++; if (int'(rsp_id) != exp_id) begin errors++; $display("FAIL rr_id got=%0d exp=%0d", rsp_id, exp_id); end
        checks++; if ({eq, gt, lt} !== {exp_eq, exp_gt, exp_lt}) begin errors++; $display("FAIL rr_flags got=%b exp=%b", {eq, gt, lt}, {exp_eq, exp_gt, exp_lt}); end
      end
      if (ready != '0) g.push_back($clog2(ready));
      tick();
    end
    checks++;
    if (g.size() != 5) begin
      errors++; $display("FAIL rr_grant_count got=%0d exp=5", g.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (g[i] != order[i]) begin errors++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", i, g[i], order[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    valid = 4'b0010;
    d0[1*DW +: DW] = 8'h33;
    d1[1*DW +: DW] = 8'h44;
    rsp_ready = 1'b0;
    tick();
    valid = '1;
    tick();
    repeat (10) begin
      d0 = $urandom;
      d1 = $urandom;
      #1;
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got=%b exp=1", rsp_valid); end
      checks++; if (rsp_id !== 2'd1) begin errors++; $display("FAIL bp_id got=%0d exp=1", rsp_id); end
      checks++; if ({eq, gt, lt} !== 3'b001) begin errors++; $display("FAIL bp_flags got=%b exp=001", {eq, gt, lt}); end
      checks++; if (ready !== 4'b0000) begin errors++; $display("FAIL bp_req_ready got=%b exp=0000", ready); end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_release_valid got=%b exp=1", rsp_valid); end
    tick();
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_after_valid got=%b exp=0", rsp_valid); end
    checks++; if (ready !== 4'b0100) begin errors++; $display("FAIL bp_next_grant got=%b exp=0100", ready); end
    valid = '0;
  endtask

  task automatic test_compare_boundary();
    logic [DW-1:0] ta[4] = '{8'hFF, 8'h80, 8'h00, 8'h7F};
    logic [DW-1:0] tb[4] = '{8'h01, 8'h7F, 8'h00, 8'h80};
    bit e, g, l;
    apply_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      valid = 4'b0001;
      d0[0 +: DW] = ta[i];
      d1[0 +: DW] = tb[i];
      tick();
      valid = '0;
      tick();
      #1;
      flags_of(ta[i], tb[i], e, g, l);
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL cmp_valid[%0d] got=%b exp=1", i, rsp_valid); end
      checks++; if ({eq, gt, lt} !== {e, g, l}) begin errors++; $display("FAIL cmp_flags[%0d] got=%b exp=%b", i, {eq, gt, lt}, {e, g, l}); end
      if (i == 0) begin
`ifdef CMP_ARB_SIGNED_EN
        checks++; if (lt !== 1'b1) begin errors++; $display("FAIL cmp_ff_01_lower got=%b exp=1", lt); end
`else
        checks++; if (gt !== 1'b1) begin errors++; $display("FAIL cmp_ff_01_greater got=%b exp=1", gt); end
`endif
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    valid = 4'b0010;
    d0 = $urandom;
    d1 = $urandom;
    rsp_ready = 1'b0;
    tick();
    valid = '0;
    #1;
    rst = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", rsp_valid); end
    checks++; if (ready !== 4'b0000) begin errors++; $display("FAIL rstmid_ready got=%b exp=0000", ready); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL rstmid_id got=%0d exp=0", rsp_id); end
    checks++; if ({eq, gt, lt} !== 3'b000) begin errors++; $display("FAIL rstmid_flags got=%b exp=000", {eq, gt, lt}); end
    model_reset();
    tick();
    rst   = 1'b0;
    valid = 4'b1001;
    #1;
    checks++; if (ready !== 4'b0001) begin errors++; $display("FAIL rstmid_ptr_grant got=%b exp=0001", ready); end
    tick();
    valid = '0;
    tick();
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin errors++; $display("FAIL rstmid_rsp got=%b/%0d exp=1/0", rsp_valid, rsp_id); end
    // Reset while a response is stalled must drop rsp_valid without a clock edge.
    rst = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rstrsp_valid got=%b exp=0", rsp_valid); end
    model_reset();
    tick();
    rst = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rstrsp_after got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_drop_valid();
    apply_reset();
    valid = 4'b0001;
    d0 = $urandom;
    d1 = $urandom;
    rsp_ready = 1'b0;
    tick();
    valid = '0;
    tick();
    valid = 4'b0010;
    #1;
    checks++; if (ready !== 4'b0000) begin errors++; $display("FAIL drop_ready got=%b exp=0000", ready); end
    tick();
    valid = '0;
    repeat (3) tick();
    rsp_ready = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin errors++; $display("FAIL drop_rsp got=%b/%0d exp=1/0", rsp_valid, rsp_id); end
    tick();
    repeat (4) begin
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL drop_no_result got=%b exp=0", rsp_valid); end
      checks++; if (ready !== 4'b0000) begin errors++; $display("FAIL drop_no_grant got=%b exp=0000", ready); end
      tick();
    end
  endtask

  task automatic test_random();
    apply_reset();
    repeat (600) begin
      valid     = N'($urandom);
      d0        = $urandom;
      d1        = ($urandom_range(0, 3) == 0) ? d0 : (N*DW)'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      model_expect();
      checks++; if (ready !== exp_ready) begin errors++; $display("FAIL rand_ready got=%b exp=%b", ready, exp_ready); end
      checks++; if (rsp_valid !== exp_valid) begin errors++; $display("FAIL rand_rsp_valid got=%b exp=%b", rsp_valid, exp_valid); end
      if (exp_valid) begin
        checks++; if (int'(rsp_id) != exp_id) begin errors++; $display("FAIL rand_id got=%0d exp=%0d", rsp_id, exp_id); end
        checks++; if ({eq, gt, lt} !== {exp_eq, exp_gt, exp_lt}) begin errors++; $display("FAIL rand_flags got=%b exp=%b", {eq, gt, lt}, {exp_eq, exp_gt, exp_lt}); end
        checks++; if ((int'(eq) + int'(gt) + int'(lt)) != 1) begin errors++; $display("FAIL rand_onehot got=%b exp=one-hot", {eq, gt, lt}); end
      end
      tick();
    end
  endtask

  initial begin
    rst       = 1'b1;
    valid     = '0;
    d0        = '0;
    d1        = '0;
    rsp_ready = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_compare_boundary();
    test_reset_mid();
    test_drop_valid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
